// File: rtl/lab2_pkg.sv
// lab2_pkg: shared state encoding and source ids for the lab2 round-robin select stage.
package lab2_pkg;
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;
    localparam logic SRC_X = 1'b0;
    localparam logic SRC_Y = 1'b1;
endpackage

// File: rtl/lab2_rr_pick.sv
// lab2_rr_pick: combinational 2-way round-robin picker; on contention the lane that did not win last time wins.
module lab2_rr_pick
    import lab2_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);
    always_comb begin
        winner = (req == 2'b11) ? ~last : (req[1] ? SRC_Y : SRC_X);
        gnt    = (req == 2'b00) ? 2'b00 : (winner == SRC_Y ? 2'b10 : 2'b01);
    end
endmodule

// File: rtl/lab2_2_rr_select_arbiter.sv
// lab2_2_rr_select_arbiter: round-robin valid/ready select stage with a 1-entry output buffer.
// Optional LAB2_ARB_STATS_EN adds saturating per-lane accept counters x_cnt/y_cnt.
module lab2_2_rr_select_arbiter
    import lab2_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter bit FIRST_SRC = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ready,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y_data,
    output logic             y_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             s,
    input  logic             out_ready
`ifdef LAB2_ARB_STATS_EN
    ,
    output logic [7:0]       x_cnt,
    output logic [7:0]       y_cnt
`endif
);
    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             s_q, s_d;
    logic             load_en, accept, win;
    logic [1:0]       gnt;

    lab2_rr_pick u_pick (
        .req    ({y_valid, x_valid}),
        .last   (last_q),
        .gnt    (gnt),
        .winner (win)
    );

    always_comb begin
        load_en = (state_q == ST_EMPTY) | out_ready;
        accept  = load_en & (|gnt);
        state_d = state_q;
        last_d  = last_q;
        data_d  = data_q;
        s_d     = s_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = (win == SRC_Y) ? y_data : x_data;
            s_d     = win;
            last_d  = win;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Readies are forced low while reset is held so no upstream word is consumed into a flop that cannot load.
    assign x_ready   = rst_n & load_en & gnt[0];
    assign y_ready   = rst_n & load_en & gnt[1];
    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign s         = s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            last_q  <= ~FIRST_SRC;
            data_q  <= '0;
            s_q     <= SRC_X;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            s_q     <= s_d;
        end
    end

`ifdef LAB2_ARB_STATS_EN
    logic [7:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;

    always_comb begin
        x_cnt_d = (accept && win == SRC_X && x_cnt_q != 8'hFF) ? x_cnt_q + 8'd1 : x_cnt_q;
        y_cnt_d = (accept && win == SRC_Y && y_cnt_q != 8'hFF) ? y_cnt_q + 8'd1 : y_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else begin
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
        end
    end

    assign x_cnt = x_cnt_q;
    assign y_cnt = y_cnt_q;
`endif
endmodule

// File: tb/tb_lab2_2_rr_select_arbiter.sv
// tb_lab2_2_rr_select_arbiter: directed and random stimulus against a queue-based reference of the select stage.
module tb_lab2_2_rr_select_arbiter;
    logic       clk;
    logic       rst_n;
    logic       x_valid, y_valid, x_ready, y_ready;
    logic [1:0] x_data, y_data, out_data;
    logic       out_valid, s, out_ready;
`ifdef LAB2_ARB_STATS_EN
    logic [7:0] x_cnt, y_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    bit [2:0]   mq[$];
    logic [1:0] m_data;
    logic       m_s;
    logic       m_last;
    int         m_xcnt, m_ycnt;

    lab2_2_rr_select_arbiter #(.WIDTH(2), .FIRST_SRC(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_valid   (x_valid),
        .x_data    (x_data),
        .x_ready   (x_ready),
        .y_valid   (y_valid),
        .y_data    (y_data),
        .y_ready   (y_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .s         (s),
        .out_ready (out_ready)
`ifdef LAB2_ARB_STATS_EN
        ,
        .x_cnt     (x_cnt),
        .y_cnt     (y_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_gnt(input bit xv, input bit yv, input bit ordy);
        if (!(mq.size() == 0 || ordy)) return 2'b00;
        if (xv && yv) return m_last ? 2'b01 : 2'b10;
        return {yv, xv};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_data = 2'd0;
        m_s    = 1'b0;
        m_last = 1'b1;
        m_xcnt = 0;
        m_ycnt = 0;
    endtask

    task automatic cycle(input bit xv, input logic [1:0] xd, input bit yv, input logic [1:0] yd, input bit ordy);
        logic [1:0] g;
        x_valid = xv; x_data = xd; y_valid = yv; y_data = yd; out_ready = ordy;
        #1;
        g = exp_gnt(xv, yv, ordy);
        check("x_ready", x_ready, g[0]);
        check("y_ready", y_ready, g[1]);
        @(posedge clk);
        if (ordy && mq.size() != 0) void'(mq.pop_front());
        if (g != 2'b00) begin
            m_s    = g[1];
            m_data = g[1] ? yd : xd;
            m_last = g[1];
            mq.push_back({m_s, m_data});
            if (g[1]) m_ycnt = (m_ycnt < 255) ? m_ycnt + 1 : 255;
            else      m_xcnt = (m_xcnt < 255) ? m_xcnt + 1 : 255;
        end
        @(negedge clk);
        check("out_valid", out_valid, mq.size() != 0);
        check("out_data", out_data, m_data);
        check("s", s, m_s);
`ifdef LAB2_ARB_STATS_EN
        check("x_cnt", x_cnt, m_xcnt);
        check("y_cnt", y_cnt, m_ycnt);
`endif
    endtask

    task automatic do_reset();
        x_valid = 1'b1; y_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_x_ready", x_ready, 1'b0);
        check("rst_y_ready", y_ready, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        x_valid = 1'b1; y_valid = 1'b1;
        x_data = 2'd0; y_data = 2'd0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_s", s, 1'b0);
        check("rst_out_data", out_data, 2'd0);
        check("rst_x_ready", x_ready, 1'b0);
        check("rst_y_ready", y_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 2'd1, 1, 2'd3, 1);
        check("first_grant_x", s, 1'b0);

        cycle(1, 2'b10, 0, 2'd0, 1);
        check("single_data", out_data, 2'b10);
        check("single_s", s, 1'b0);

        for (int i = 0; i < 3; i++) begin
            cycle(1, 2'd1, 1, 2'd3, 1);
            check("cont_s", s, (i % 2 == 0) ? 1'b1 : 1'b0);
            check("cont_data", out_data, (i % 2 == 0) ? 2'd3 : 2'd1);
        end

        for (int i = 0; i < 3; i++) begin
            cycle(1, 2'd1, 1, 2'd3, 0);
            check("bp_data", out_data, 2'd3);
            check("bp_s", s, 1'b1);
        end
        cycle(1, 2'd1, 1, 2'd3, 1);
        check("bp_release_s", s, 1'b0);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_x_ready", x_ready, 1'b0);
        check("async_y_ready", y_ready, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 2'd2, 1, 2'd3, 1);
        check("post_async_first_x", s, 1'b0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            cycle($urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1), 2'($urandom),
                  $urandom_range(0, 9) < 7);
        end

`ifdef LAB2_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 300; i++) cycle(0, 2'd0, 1, 2'($urandom), 1);
        check("y_cnt_sat", y_cnt, 8'd255);
        check("x_cnt_zero", x_cnt, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
